// File: rtl/fifo_flags_pkg.sv
// fifo_flags_pkg: default geometry/thresholds and level-width helper shared by the FIFO files
package fifo_flags_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int AF_THRESH_DEF  = 12;
    localparam int AE_THRESH_DEF  = 2;

    // Level counts 0..DEPTH inclusive, so it needs one bit more than the pointers
    function automatic int lvl_w(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: storage array with one synchronous write port and one asynchronous read port
module fifo_ram
    import fifo_flags_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with FWFT/registered read, threshold flags, fill level,
// sticky overflow/underflow and synchronous flush
module fifo_flags
    import fifo_flags_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = AF_THRESH_DEF,
    parameter int AE_THRESH  = AE_THRESH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic                           dout_valid,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [lvl_w(ADDR_WIDTH)-1:0]   level,
    output logic                           overflow,
    output logic                           underflow,
    input  logic                           clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = lvl_w(ADDR_WIDTH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_param
        $error("fifo_flags: illegal AF_THRESH/AE_THRESH for this depth");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign level        = level_q;
    assign full         = level_q == LW'(DEPTH);
    assign empty        = level_q == '0;
    assign almost_full  = level_q >= LW'(AF_THRESH);
    assign almost_empty = level_q <= LW'(AE_THRESH);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Flush masks both requests, so it also suppresses error-flag set events that cycle
    always_comb begin
        wr_acc   = wr_en & ~full & ~flush;
        rd_acc   = rd_en & ~empty & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_WIDTH'(rd_acc);
        level_d  = flush ? '0 :
                   (wr_acc & ~rd_acc) ? level_q + LW'(1) :
                   (rd_acc & ~wr_acc) ? level_q - LW'(1) : level_q;
        ovf_d    = (wr_en & full & ~flush) | (ovf_q & ~clr_err);
        unf_d    = (rd_en & empty & ~flush) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign dout       = ram_rdata;
        assign dout_valid = ~empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  dv_q;
        assign dout_d = rd_acc ? ram_rdata : dout_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dout_q <= dout_d;
                dv_q   <= rd_acc;
            end
        end
        assign dout       = dout_q;
        assign dout_valid = dv_q;
    end

endmodule
